data_mem_responder: RTL and testbench

Multi-cycle responder for the MEM-stage data-memory request interface. It replaces the zero-latency data RAM with a 256×8 byte array accessed one byte per clock. It accepts a request from the EX/MEM outputs (enable, R/W, size, address, store data) and holds Busy so the hazard unit can freeze the pipeline. It pulses Ready when the load data is valid or the store has committed.

---
 rtl/mem_if_pkg.sv | 39 +++
 rtl/byte_array.sv | 23 ++
 rtl/data_mem_responder.sv | 119 +++++++++++
 tb/tb_data_mem_responder.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mem_if_pkg.sv
// Shared MEM-stage request codes, responder state encoding and request decode helpers.
package mem_if_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic MEM_LOAD  = 1'b0;
  localparam logic MEM_STORE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_XFER = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Number of bytes in the item minus one; illegal sizes never reach XFER.
  function automatic logic [1:0] size_last(input logic [1:0] size);
    logic [1:0] r;
    case (size)
      SZ_HALF: r = 2'd1;
      SZ_WORD: r = 2'd3;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  function automatic logic req_bad(input logic [1:0] size, input logic [1:0] addr_lo);
    logic r;
    case (size)
      SZ_BYTE: r = 1'b0;
      SZ_HALF: r = addr_lo[0];
      SZ_WORD: r = (addr_lo != 2'b00);
      default: r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/byte_array.sv
// DEPTH x 8 storage: synchronous write port, asynchronous read port, contents not reset.
module byte_array #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [7:0]    i_wdata,
  output logic [7:0]    o_rdata
);

  logic [7:0] Mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      Mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = Mem[i_addr];

endmodule

// File: rtl/data_mem_responder.sv
// Byte-serial data-memory responder: Busy stalls the pipe while N bytes move one per clock,
// Ready pulses N+1 edges after acceptance (1 edge for illegal/misaligned requests, with Error).
module data_mem_responder
  import mem_if_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        Mem_Enable,
  input  logic        Mem_RW,
  input  logic [1:0]  Mem_Size,
  input  logic [31:0] Address,
  input  logic [31:0] Data_In,
  output logic [31:0] Data_Out,
  output logic        Busy,
  output logic        Ready,
  output logic        Error
);

  localparam int AW = $clog2(DEPTH);

  state_t        r_state;
  state_t        w_next;
  logic          r_rw;
  logic [AW-1:0] r_idx;
  logic [31:0]   r_data;
  logic [31:0]   r_asm;
  logic [31:0]   r_dout;
  logic [1:0]    r_cnt;
  logic          r_busy;
  logic          r_err;

  logic          w_bad;
  logic          w_last;
  logic          w_we;
  logic [7:0]    w_rd_byte;
  logic [7:0]    w_wr_byte;
  logic          w_unused_addr;

  assign w_unused_addr = ^Address[31:AW];

  assign w_bad  = req_bad(Mem_Size, Address[1:0]);
  assign w_last = (r_cnt == 2'd0);
  assign w_we   = (r_state == ST_XFER) && (r_rw == MEM_STORE);
  // Counter runs N-1..0, so it directly selects the big-endian byte to store.
  assign w_wr_byte = r_data[{r_cnt, 3'b000} +: 8];

  byte_array #(.DEPTH(DEPTH)) u_arr (
    .i_clk   (CLK),
    .i_we    (w_we),
    .i_addr  (r_idx),
    .i_wdata (w_wr_byte),
    .o_rdata (w_rd_byte)
  );

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (Mem_Enable) w_next = w_bad ? ST_DONE : ST_XFER;
      ST_XFER: if (w_last) w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_rw   <= MEM_LOAD;
      r_idx  <= '0;
      r_data <= '0;
      r_asm  <= '0;
      r_dout <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (Mem_Enable) begin
            r_rw   <= Mem_RW;
            r_idx  <= Address[AW-1:0];
            r_data <= Data_In;
            r_cnt  <= size_last(Mem_Size);
            r_asm  <= '0;
            r_busy <= !w_bad;
            r_err  <= w_bad;
          end
        end
        ST_XFER: begin
          r_idx <= r_idx + AW'(1);
          r_asm <= {r_asm[23:0], w_rd_byte};
          if (w_last) begin
            r_busy <= 1'b0;
            // Last byte lands in Data_Out on the same edge it is read.
            if (r_rw == MEM_LOAD) r_dout <= {r_asm[23:0], w_rd_byte};
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign Data_Out = r_dout;
  assign Busy     = r_busy;
  assign Ready    = (r_state == ST_DONE);
  assign Error    = (r_state == ST_DONE) && r_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed and randomized checks of data_mem_responder against a byte-array reference model.
module tb_data_mem_responder;

  logic        CLK = 1'b0;
  logic        CLR;
  logic        Mem_Enable;
  logic        Mem_RW;
  logic [1:0]  Mem_Size;
  logic [31:0] Address;
  logic [31:0] Data_In;
  logic [31:0] Data_Out;
  logic        Busy;
  logic        Ready;
  logic        Error;

  int          total = 0;
  int          bad = 0;
  logic [7:0]  mdl [256];
  logic [31:0] exp_dout;

  data_mem_responder #(.DEPTH(256)) dut (
    .CLK        (CLK),
    .CLR        (CLR),
    .Mem_Enable (Mem_Enable),
    .Mem_RW     (Mem_RW),
    .Mem_Size   (Mem_Size),
    .Address    (Address),
    .Data_In    (Data_In),
    .Data_Out   (Data_Out),
    .Busy       (Busy),
    .Ready      (Ready),
    .Error      (Error)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_mem(input int k);
    check("mem", 32'(dut.u_arr.Mem[k]), 32'(mdl[k]));
  endtask

  // Issues one request from a negedge and follows it to Ready and back to IDLE.
  task automatic run_req(input logic rw, input logic [1:0] sz, input logic [31:0] addr,
                         input logic [31:0] din, input bit hold);
    int         n;
    int         edges;
    int         busy_n;
    int         exp_edges;
    logic       bad_req;
    logic [7:0] idx;
    logic [31:0] asm_v;
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    bad_req = (sz == 2'b11) || (sz == 2'b01 && addr[0]) || (sz == 2'b10 && addr[1:0] != 2'b00);
    exp_edges = bad_req ? 1 : n + 1;
    Mem_Enable = 1'b1;
    Mem_RW     = rw;
    Mem_Size   = sz;
    Address    = addr;
    Data_In    = din;
    edges  = 0;
    busy_n = 0;
    while (edges < 20) begin
      @(posedge CLK);
      edges++;
      @(negedge CLK);
      if (Ready) break;
      if (Busy) busy_n++;
      check("dout_steady", Data_Out, exp_dout);
      // Fields are latched at acceptance; disturbing them must not matter.
      Mem_RW   = 1'($urandom());
      Mem_Size = 2'($urandom());
      Address  = $urandom();
      Data_In  = $urandom();
    end
    check("latency", edges, exp_edges);
    check("busy_cycles", busy_n, bad_req ? 0 : n);
    check("busy_at_ready", 32'(Busy), 0);
    check("error", 32'(Error), 32'(bad_req));
    asm_v = 32'h0;
    if (!bad_req) begin
      for (int i = 0; i < n; i++) begin
        idx = addr[7:0] + 8'(i);
        if (rw) mdl[idx] = 8'(din >> (8 * (n - 1 - i)));
        else    asm_v = (asm_v << 8) | 32'(mdl[idx]);
      end
      if (!rw) exp_dout = asm_v;
    end
    check("data_out", Data_Out, exp_dout);
    if (!hold) Mem_Enable = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    check("ready_pulse", 32'(Ready), 0);
    check("idle_busy", 32'(Busy), 0);
  endtask

  initial begin
    logic [7:0]  v;
    logic [1:0]  sz;
    logic [31:0] a;
    CLR = 1'b1;
    Mem_Enable = 1'b0;
    Mem_RW = 1'b0;
    Mem_Size = 2'b00;
    Address = 32'h0;
    Data_In = 32'h0;
    exp_dout = 32'h0;
    for (int k = 0; k < 256; k++) begin
      v = 8'($urandom());
      mdl[k] = v;
      dut.u_arr.Mem[k] = v;
    end
    mdl[8] = 8'hDE; mdl[9] = 8'hAD; mdl[10] = 8'hBE; mdl[11] = 8'hEF;
    dut.u_arr.Mem[8] = 8'hDE; dut.u_arr.Mem[9] = 8'hAD;
    dut.u_arr.Mem[10] = 8'hBE; dut.u_arr.Mem[11] = 8'hEF;

    @(negedge CLK);
    @(negedge CLK);
    check("rst_dout", Data_Out, 0);
    check("rst_busy", 32'(Busy), 0);
    check("rst_ready", 32'(Ready), 0);
    check("rst_error", 32'(Error), 0);
    CLR = 1'b0;
    @(negedge CLK);

    run_req(1'b0, 2'b10, 32'd8, 32'h0, 1'b0);
    check("load_word_8", Data_Out, 32'hDEADBEEF);
    run_req(1'b0, 2'b01, 32'd10, 32'h0, 1'b0);
    check("load_half_10", Data_Out, 32'h0000BEEF);
    run_req(1'b0, 2'b00, 32'hFFFF_FF09, 32'h0, 1'b0);
    check("load_byte_9", Data_Out, 32'h000000AD);

    run_req(1'b1, 2'b10, 32'd20, 32'h12345678, 1'b0);
    check("store_keeps_dout", Data_Out, 32'h000000AD);
    check("mem20", 32'(dut.u_arr.Mem[20]), 32'h12);
    check("mem23", 32'(dut.u_arr.Mem[23]), 32'h78);
    run_req(1'b0, 2'b10, 32'd20, 32'h0, 1'b0);
    check("load_word_20", Data_Out, 32'h12345678);

    run_req(1'b0, 2'b10, 32'd6, 32'h0, 1'b0);
    run_req(1'b1, 2'b11, 32'd4, 32'hFFFFFFFF, 1'b0);
    run_req(1'b1, 2'b01, 32'd5, 32'hFFFFFFFF, 1'b0);
    check("err_keeps_dout", Data_Out, 32'h12345678);
    for (int k = 4; k < 8; k++) check_mem(k);

    // Reset in the middle of a word store.
    Mem_Enable = 1'b1; Mem_RW = 1'b1; Mem_Size = 2'b10;
    Address = 32'd40; Data_In = 32'hAABBCCDD;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    CLR = 1'b1;
    #1;
    check("clr_busy", 32'(Busy), 0);
    check("clr_ready", 32'(Ready), 0);
    check("clr_error", 32'(Error), 0);
    check("clr_dout", Data_Out, 0);
    @(posedge CLK);
    @(negedge CLK);
    check("clr_no_ready", 32'(Ready), 0);
    CLR = 1'b0;
    Mem_Enable = 1'b0;
    mdl[40] = 8'hAA;
    mdl[41] = 8'hBB;
    exp_dout = 32'h0;
    check("mem40", 32'(dut.u_arr.Mem[40]), 32'hAA);
    check("mem41", 32'(dut.u_arr.Mem[41]), 32'hBB);
    for (int k = 40; k < 44; k++) check_mem(k);
    @(negedge CLK);
    run_req(1'b0, 2'b10, 32'd40, 32'h0, 1'b0);

    // Enable left high through DONE: one Ready per request, re-accept from IDLE.
    run_req(1'b0, 2'b00, 32'd9, 32'h0, 1'b1);
    run_req(1'b0, 2'b00, 32'd9, 32'h0, 1'b0);
    check("hold_byte_9", Data_Out, 32'h000000AD);

    for (int t = 0; t < 60; t++) begin
      sz = 2'($urandom_range(0, 3));
      a = $urandom();
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz == 2'b10) a[1:0] = 2'b00;
      end
      run_req(1'($urandom()), sz, a, $urandom(), 1'b0);
    end

    for (int k = 0; k < 256; k++) check_mem(k);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
